// File: rtl/reg_bank_ctrl.sv
// Request/response initiator for the 8 x 8-bit register bank: single writes, single reads, full scan.
// Optional write readback check is enabled by defining REG_BANK_CTRL_VERIFY_EN (adds the wr_err port).
module reg_bank_ctrl #(
    parameter int DW     = 8,
    parameter int AW     = 3,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    input  logic          scan_start,
    output logic          scan_busy,
    output logic          scan_done,
    output logic [DW-1:0] bank_in,
    output logic [AW-1:0] bank_load,
    output logic          bank_we,
    output logic [AW-1:0] bank_sel,
`ifdef REG_BANK_CTRL_VERIFY_EN
    output logic          wr_err,
`endif
    input  logic [DW-1:0] bank_out
);

    // state     | meaning
    // IDLE      | ready for a request or scan_start
    // WR        | bank_we high, bank captures at the end of this cycle
    // RD_WAIT   | waiting RD_LAT cycles for bank_out after bank_sel change
    // RD_CAP    | bank_out valid, registered into the response
    // SCAN_WAIT | scan: waiting for bank_out of the current address
    // SCAN_CAP  | scan: capture current address, advance or finish
    // VRF_WAIT  | readback of the written address (verify build only)
    // VRF_CHK   | compare readback with written data (verify build only)
    typedef enum logic [2:0] {
        IDLE, WR, RD_WAIT, RD_CAP, SCAN_WAIT, SCAN_CAP, VRF_WAIT, VRF_CHK
    } state_t;

    localparam logic [1:0]    LP_WAIT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
    localparam logic [AW-1:0] LP_LAST_ADDR = '1;

    state_t        r_state;
    state_t        w_next;
    logic          r_ready_en;
    logic [1:0]    r_wait_cnt;
    logic          w_wait_done;
    logic          w_idle;
    logic          w_in_wait;
    logic          r_rsp_valid;
    logic [AW-1:0] r_rsp_addr;
    logic [DW-1:0] r_rsp_data;
    logic          r_scan_busy;
    logic          r_scan_done;
    logic [DW-1:0] r_bank_in;
    logic [AW-1:0] r_bank_load;
    logic [AW-1:0] r_bank_sel;
`ifdef REG_BANK_CTRL_VERIFY_EN
    logic          r_wr_err;
`endif

    // r_ready_en keeps req_ready low during the reset cycle itself.
    assign w_idle      = (r_state == IDLE) && r_ready_en;
    assign w_wait_done = (r_wait_cnt == 2'd0);
    assign w_in_wait   = (r_state == RD_WAIT) || (r_state == SCAN_WAIT) || (r_state == VRF_WAIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_idle && scan_start) begin
                    if (RD_LAT == 0) w_next = SCAN_CAP;
                    else             w_next = SCAN_WAIT;
                end else if (w_idle && req_valid) begin
                    if (req_write)        w_next = WR;
                    else if (RD_LAT == 0) w_next = RD_CAP;
                    else                  w_next = RD_WAIT;
                end
            end
            WR: begin
`ifdef REG_BANK_CTRL_VERIFY_EN
                if (RD_LAT == 0) w_next = VRF_CHK;
                else             w_next = VRF_WAIT;
`else
                w_next = IDLE;
`endif
            end
            RD_WAIT:   if (w_wait_done) w_next = RD_CAP;
            RD_CAP:    w_next = IDLE;
            SCAN_WAIT: if (w_wait_done) w_next = SCAN_CAP;
            SCAN_CAP: begin
                if (r_bank_sel == LP_LAST_ADDR) w_next = IDLE;
                else if (RD_LAT == 0)           w_next = SCAN_CAP;
                else                            w_next = SCAN_WAIT;
            end
            VRF_WAIT:  if (w_wait_done) w_next = VRF_CHK;
            VRF_CHK:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_en  <= 1'b0;
            r_wait_cnt  <= LP_WAIT_LOAD;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_scan_busy <= 1'b0;
            r_scan_done <= 1'b0;
            r_bank_in   <= '0;
            r_bank_load <= '0;
            r_bank_sel  <= '0;
`ifdef REG_BANK_CTRL_VERIFY_EN
            r_wr_err    <= 1'b0;
`endif
        end else begin
            r_ready_en  <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_scan_done <= 1'b0;
`ifdef REG_BANK_CTRL_VERIFY_EN
            r_wr_err    <= 1'b0;
`endif
            // Down-counter reloads whenever a wait state is (re)entered.
            if (w_in_wait && (w_next == r_state)) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end else begin
                r_wait_cnt <= LP_WAIT_LOAD;
            end

            case (r_state)
                IDLE: begin
                    if (w_idle && scan_start) begin
                        r_bank_sel  <= '0;
                        r_scan_busy <= 1'b1;
                    end else if (w_idle && req_valid) begin
                        if (req_write) begin
                            r_bank_in   <= req_wdata;
                            r_bank_load <= req_addr;
                        end else begin
                            r_bank_sel  <= req_addr;
                        end
                    end
                end
`ifdef REG_BANK_CTRL_VERIFY_EN
                WR: r_bank_sel <= r_bank_load;
                VRF_CHK: r_wr_err <= (bank_out != r_bank_in);
`endif
                RD_CAP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_addr  <= r_bank_sel;
                    r_rsp_data  <= bank_out;
                end
                SCAN_CAP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_addr  <= r_bank_sel;
                    r_rsp_data  <= bank_out;
                    if (r_bank_sel == LP_LAST_ADDR) begin
                        r_scan_busy <= 1'b0;
                        r_scan_done <= 1'b1;
                    end else begin
                        r_bank_sel  <= r_bank_sel + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_idle;
    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_data  = r_rsp_data;
    assign scan_busy = r_scan_busy;
    assign scan_done = r_scan_done;
    assign bank_in   = r_bank_in;
    assign bank_load = r_bank_load;
    assign bank_we   = (r_state == WR);
    assign bank_sel  = r_bank_sel;
`ifdef REG_BANK_CTRL_VERIFY_EN
    assign wr_err    = r_wr_err;
`endif

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl: vector table for single reads/writes, hand sequences for scan,
// reset and (with REG_BANK_CTRL_VERIFY_EN) the write readback check.
module tb_reg_bank_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          scan_start, scan_busy, scan_done;
    logic [DW-1:0] bank_in;
    logic [AW-1:0] bank_load;
    logic          bank_we;
    logic [AW-1:0] bank_sel;
    logic [DW-1:0] bank_out;
`ifdef REG_BANK_CTRL_VERIFY_EN
    logic          wr_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
        .bank_in(bank_in), .bank_load(bank_load), .bank_we(bank_we), .bank_sel(bank_sel),
`ifdef REG_BANK_CTRL_VERIFY_EN
        .wr_err(wr_err),
`endif
        .bank_out(bank_out)
    );

    // Bank model: write on clock edge, one-cycle registered read of bank_sel.
    logic [DW-1:0] mem [0:7];
    logic [DW-1:0] store_val;
    always_comb begin
        store_val = bank_in;
`ifdef REG_BANK_CTRL_VERIFY_EN
        if (bank_load == 3'd2 && bank_in == 8'hFF) store_val = 8'hFE;
`endif
    end
    always @(posedge clk) begin
        if (bank_we) mem[bank_load] <= store_val;
        bank_out <= mem[bank_sel];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 20) begin
            tick();
            t++;
        end
        chk("wait_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"},    {31'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_v"},    {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_addr"}, {29'd0, rsp_addr},  32'd0);
        chk({tag, "_rsp_data"}, {24'd0, rsp_data},  32'd0);
        chk({tag, "_busy"},     {31'd0, scan_busy}, 32'd0);
        chk({tag, "_done"},     {31'd0, scan_done}, 32'd0);
        chk({tag, "_we"},       {31'd0, bank_we},   32'd0);
        chk({tag, "_bank_in"},  {24'd0, bank_in},   32'd0);
        chk({tag, "_load"},     {29'd0, bank_load}, 32'd0);
        chk({tag, "_sel"},      {29'd0, bank_sel},  32'd0);
    endtask

    typedef struct {
        logic          valid;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          e_ready;
        logic          e_we;
        logic [AW-1:0] e_load;
        logic [DW-1:0] e_in;
        logic          e_rv;
        logic [AW-1:0] e_raddr;
        logic [DW-1:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic er, input logic ewe,
                                input logic [AW-1:0] el, input logic [DW-1:0] ein,
                                input logic erv, input logic [AW-1:0] era,
                                input logic [DW-1:0] erd);
        vec_t r;
        r.valid = v; r.write = w; r.addr = a; r.wdata = d;
        r.e_ready = er; r.e_we = ewe; r.e_load = el; r.e_in = ein;
        r.e_rv = erv; r.e_raddr = era; r.e_rdata = erd;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        int n_rsp, c, ready_viol, we_viol, rv_after, busy_after, done_seen;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        scan_start = 1'b0;

        // Each row: inputs held for one cycle, expected outputs sampled after the edge.
        vecs.push_back(mk(1, 1, 3, 8'hA5, 0, 1, 3, 8'hA5, 0, 0, 0));   // accept write -> WR
`ifdef REG_BANK_CTRL_VERIFY_EN
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));       // VRF_WAIT
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));       // VRF_CHK
`endif
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0));       // IDLE
        vecs.push_back(mk(1, 0, 3, 8'h00, 0, 0, 0, 0, 0, 0, 0));       // read 3 -> RD_WAIT
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));       // RD_CAP
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 3, 8'hA5));   // response
        vecs.push_back(mk(1, 1, 5, 8'h3C, 0, 1, 5, 8'h3C, 0, 0, 0));   // write 5 -> WR
`ifdef REG_BANK_CTRL_VERIFY_EN
        vecs.push_back(mk(1, 0, 5, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 5, 8'h00, 0, 0, 0, 0, 0, 0, 0));
`endif
        vecs.push_back(mk(1, 0, 5, 8'h00, 1, 0, 0, 0, 0, 0, 0));       // read held, not yet accepted
        vecs.push_back(mk(1, 0, 5, 8'h00, 0, 0, 0, 0, 0, 0, 0));       // accepted -> RD_WAIT
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 5, 8'h3C));   // fresh data
        vecs.push_back(mk(1, 0, 3, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 3, 8'hA5));   // addr 3 untouched
        vecs.push_back(mk(0, 1, 3, 8'h00, 1, 0, 0, 0, 0, 0, 0));       // write without valid ignored
        vecs.push_back(mk(1, 0, 3, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 3, 8'hA5));

        // Power-on reset held two cycles.
        tick();
        check_reset_state("por1");
        tick();
        check_reset_state("por2");
        rst = 1'b0;
        tick();
        chk("por_release_ready", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            req_valid = vecs[i].valid; req_write = vecs[i].write;
            req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
            tick();
            chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_we", i),    {31'd0, bank_we},   {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_rv", i),    {31'd0, rsp_valid}, {31'd0, vecs[i].e_rv});
            chk($sformatf("v%0d_busy", i),  {31'd0, scan_busy}, 32'd0);
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_load", i), {29'd0, bank_load}, {29'd0, vecs[i].e_load});
                chk($sformatf("v%0d_in", i),   {24'd0, bank_in},   {24'd0, vecs[i].e_in});
            end
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_raddr", i), {29'd0, rsp_addr}, {29'd0, vecs[i].e_raddr});
                chk($sformatf("v%0d_rdata", i), {24'd0, rsp_data}, {24'd0, vecs[i].e_rdata});
            end
        end
        req_valid = 1'b0;

        // Scan with a simultaneous write request and a mid-scan scan_start.
        for (int k = 0; k < 8; k++) do_write(3'(k), 8'(8'h10 + k));
        wait_ready();
        scan_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd0; req_wdata = 8'hEE;
        tick();
        scan_start = 1'b0;
        chk("scan_start_busy", {31'd0, scan_busy}, 32'd1);
        chk("scan_start_ready", {31'd0, req_ready}, 32'd0);
        chk("scan_start_no_we", {31'd0, bank_we}, 32'd0);
        n_rsp = 0; c = 0; ready_viol = 0; we_viol = 0; done_seen = 0;
        while (!done_seen && c < 40) begin
            scan_start = (c == 5);
            tick();
            c++;
            if (bank_we) we_viol++;
            if (rsp_valid) begin
                chk($sformatf("scan%0d_addr", n_rsp), {29'd0, rsp_addr}, 32'(n_rsp));
                chk($sformatf("scan%0d_data", n_rsp), {24'd0, rsp_data}, 32'(8'h10 + n_rsp));
                chk($sformatf("scan%0d_cycle", n_rsp), 32'(c), 32'((RD_LAT + 1) * (n_rsp + 1)));
                chk($sformatf("scan%0d_done", n_rsp), {31'd0, scan_done}, {31'd0, (n_rsp == 7)});
                n_rsp++;
            end else begin
                chk($sformatf("scan_c%0d_done_no_rsp", c), {31'd0, scan_done}, 32'd0);
            end
            if (scan_done) done_seen = 1;
            else if (req_ready) ready_viol++;
        end
        scan_start = 1'b0;
        chk("scan_done_seen", 32'(done_seen), 32'd1);
        chk("scan_rsp_count", 32'(n_rsp), 32'd8);
        chk("scan_ready_low", 32'(ready_viol), 32'd0);
        chk("scan_no_we", 32'(we_viol), 32'd0);
        chk("scan_busy_at_done", {31'd0, scan_busy}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("post_scan_we", {31'd0, bank_we}, 32'd1);
        chk("post_scan_load", {29'd0, bank_load}, 32'd0);
        chk("post_scan_in", {24'd0, bank_in}, 32'h0EE);
        chk("post_scan_done_pulse", {31'd0, scan_done}, 32'd0);
        rv_after = 0; busy_after = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) rv_after++;
            if (scan_busy) busy_after++;
        end
        chk("post_scan_no_rsp", 32'(rv_after), 32'd0);
        chk("post_scan_no_busy", 32'(busy_after), 32'd0);

        // Reset in the middle of a scan.
        wait_ready();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check_reset_state("mid1");
        tick();
        check_reset_state("mid2");
        rst = 1'b0;
        tick();
        chk("mid_release_ready", {31'd0, req_ready}, 32'd1);
        rv_after = 0; busy_after = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) rv_after++;
            if (scan_busy || bank_we) busy_after++;
        end
        chk("mid_no_rsp", 32'(rv_after), 32'd0);
        chk("mid_quiet", 32'(busy_after), 32'd0);

`ifdef REG_BANK_CTRL_VERIFY_EN
        begin
            int err_cnt, occ;
            do_write(3'd2, 8'hFF);
            err_cnt = 0; occ = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (wr_err) err_cnt++;
                if (!req_ready) occ++;
            end
            chk("vrf_bad_err_count", 32'(err_cnt), 32'd1);
            chk("vrf_bad_occupancy", 32'(occ), 32'(RD_LAT + 1));
            do_write(3'd4, 8'h00);
            err_cnt = 0; occ = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (wr_err) err_cnt++;
                if (rsp_valid) occ++;
            end
            chk("vrf_good_err_count", 32'(err_cnt), 32'd0);
            chk("vrf_no_rsp", 32'(occ), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
